// File: rtl/alu_sequencer.sv
// alu_sequencer: collects operand A, operand B and an opcode from a byte
// stream, presents them to an external ALU, captures the result and hands
// it to a transmitter. Guards against stalled senders (inter-byte timeout),
// unsupported opcodes and bytes that arrive while a result is in flight.
module alu_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_op_err,
  output logic               o_timeout,
  output logic               o_overrun
);

  // Counter only has to reach TIMEOUT-1.
  localparam int NB_CNT = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  alu_a_q, alu_a_d;
  logic [NB_DATA-1:0]  alu_b_q, alu_b_d;
  logic [NB_OP-1:0]    alu_op_q, alu_op_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                op_err_q, op_err_d;
  logic                timeout_q, timeout_d;
  logic                overrun_q, overrun_d;

  // MIPS funct codes the external ALU implements.
  function automatic logic op_supported(input logic [NB_OP-1:0] op);
    logic ok;
    case (op)
      NB_OP'(6'b100000): ok = 1'b1; // ADD
      NB_OP'(6'b100010): ok = 1'b1; // SUB
      NB_OP'(6'b100100): ok = 1'b1; // AND
      NB_OP'(6'b100101): ok = 1'b1; // OR
      NB_OP'(6'b100110): ok = 1'b1; // XOR
      NB_OP'(6'b100111): ok = 1'b1; // NOR
      NB_OP'(6'b000010): ok = 1'b1; // SRL
      NB_OP'(6'b000011): ok = 1'b1; // SRA
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state and next-output logic; registers hold unless a state loads them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    op_err_d   = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          alu_a_d = i_rx_data;
          cnt_d   = '0;
          state_d = WAIT_B;
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_B: begin
        // An arriving byte always beats an expiring timeout.
        if (i_rx_valid) begin
          alu_b_d = i_rx_data;
          cnt_d   = '0;
          state_d = WAIT_OP;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + NB_CNT'(1);
        end
      end

      WAIT_OP: begin
        if (i_rx_valid) begin
          cnt_d = '0;
          if (op_supported(i_rx_data[NB_OP-1:0])) begin
            alu_op_d = i_rx_data[NB_OP-1:0];
            state_d  = EXEC;
          end else begin
            op_err_d = 1'b1;
            state_d  = IDLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + NB_CNT'(1);
        end
      end

      EXEC: begin
        // ALU has had a full cycle on the registered operands.
        tx_data_d  = i_alu_res;
        tx_start_d = 1'b1;
        state_d    = SEND;
        if (i_rx_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end

      SEND: begin
        // No backpressure: a byte here is lost, even alongside tx_done.
        if (i_rx_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (i_tx_done) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      op_err_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      op_err_q   <= op_err_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_op_err   = op_err_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8, SHALL set operand/result width.
REQ-002 Parameter NB_OP, default 6, SHALL set opcode width (MIPS funct encoding).
REQ-003 Parameter TIMEOUT, default 1000, SHALL set inter-byte timeout in clock cycles.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_rx_data  in  NB_DATA  received byte.
REQ-007 i_rx_valid  in  1  one-cycle strobe, i_rx_data valid; no backpressure.
REQ-008 i_alu_res  in  NB_DATA  combinational ALU result.
REQ-009 i_tx_done  in  1  one-cycle strobe, transmitter finished byte.
REQ-010 o_alu_a / o_alu_b  out  NB_DATA each  registered ALU operands.
REQ-011 o_alu_op  out  NB_OP  registered ALU opcode.
REQ-012 o_tx_data  out  NB_DATA  registered result byte.
REQ-013 o_tx_start  out  1  one-cycle transmit request.
REQ-014 o_busy  out  1  high in any state except IDLE.
REQ-015 o_op_err  out  1  one-cycle pulse, unsupported opcode.
REQ-016 o_timeout  out  1  one-cycle pulse, inter-byte timeout.
REQ-017 o_overrun  out  1  sticky flag, byte dropped.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_B, WAIT_OP, EXEC, SEND.
REQ-019 IDLE: i_rx_valid -> load o_alu_a, go WAIT_B.
REQ-020 WAIT_B: i_rx_valid -> load o_alu_b, go WAIT_OP.
REQ-021 WAIT_OP: i_rx_valid with supported opcode (low NB_OP bits of byte) -> load o_alu_op, go EXEC; unsupported -> o_alu_op unchanged, pulse o_op_err, go IDLE.
REQ-022 Supported opcodes SHALL be ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
REQ-023 EXEC SHALL last exactly one cycle, capture i_alu_res into o_tx_data, go SEND.
REQ-024 o_tx_start SHALL pulse for exactly the first cycle in SEND; latency from opcode strobe to o_tx_start = 2 cycles.
REQ-025 SEND: i_tx_done -> go IDLE; otherwise remain, o_tx_start low.
REQ-026 i_tx_done outside SEND SHALL be ignored.
REQ-027 Timeout counter SHALL clear on every accepted byte and on entering WAIT_B; in WAIT_B/WAIT_OP it increments each cycle without i_rx_valid; reaching TIMEOUT-1 -> pulse o_timeout, go IDLE.
REQ-028 i_rx_valid in EXEC or SEND SHALL drop the byte and set o_overrun; includes same cycle as i_tx_done (done wins, byte dropped).
REQ-029 i_rx_valid on the timeout-expiry cycle SHALL be accepted normally and no timeout fires.
REQ-030 o_alu_a/b/op and o_tx_data SHALL hold last loaded values until next load; no other outputs change them.
REQ-031 Arithmetic performed by external ALU; block SHALL pass result unmodified (wrap-around, two's complement).

Reset
REQ-032 i_reset SHALL, on next rising edge, force IDLE and clear all outputs, counter and o_overrun to 0, regardless of state (including mid-sequence or SEND).
REQ-033 i_rx_valid asserted with i_reset SHALL be ignored.

Verification
REQ-034 Bytes 0x01, 0x00, 0x20 (ADD), ALU returns 0x01 -> o_tx_start two cycles after op, o_tx_data=0x01; i_tx_done -> IDLE, o_busy=0.
REQ-035 Bytes 0x30, 0x96, 0x22 (SUB), ALU 0x9A -> o_tx_data=0x9A; then 0x8F, 0xAA, 0x24 (AND) -> o_tx_data=0x8A.
REQ-036 Bytes 0x0F, 0x05, 0x3F -> o_op_err one cycle, no o_tx_start, return IDLE, o_alu_op unchanged.
REQ-037 Byte 0x0F then silence TIMEOUT cycles -> o_timeout one cycle, IDLE; next three bytes form a fresh A/B/OP.
REQ-038 Byte during SEND, and byte coincident with i_tx_done -> o_overrun=1 sticky, byte not loaded; i_reset mid-WAIT_OP -> all outputs 0, IDLE.
